pulse_sync_sched: RTL and testbench

PULSE_SYNC_SCHED -- requirements
Module: pulse_sync_sched

---
 rtl/pulse_sync_sched.sv | 141 ++++++++++++++
 tb/tb_pulse_sync_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_sched.sv
// pulse_sync_sched: round-robin scheduler feeding a fast-to-slow pulse synchronizer.
// Define PULSE_SCHED_CNT_EN for CNT_W-bit pending counters; otherwise each requester holds one pending bit.
module pulse_sync_sched #(
    parameter int NREQ  = 4,
    parameter int GAP   = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clka,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    clr_ovf,
    output logic                    sig_a,
    output logic [$clog2(NREQ)-1:0] sig_id,
    output logic                    busy,
    output logic [NREQ-1:0]         ovf
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int GAP_W = $clog2(GAP);

`ifdef PULSE_SCHED_CNT_EN
    localparam int PEND_W = CNT_W;
`else
    localparam int PEND_W = 1;
`endif

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FIRE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("pulse_sync_sched: NREQ must be in 2..8");
    end
    if (GAP < 6) begin : g_bad_gap
        $error("pulse_sync_sched: GAP must be at least 6");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pulse_sync_sched: CNT_W must be at least 1");
    end

    logic [1:0]        state;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   sel_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [PEND_W-1:0] pend [NREQ];
    logic [NREQ-1:0]   pend_nz;
    logic [NREQ-1:0]   dec_vec;
    logic [NREQ-1:0]   ovf_hit;
    logic              any_pend;
    int                arb_dist;
    int                arb_best;

    for (genvar i = 0; i < NREQ; i++) begin : g_flags
        assign pend_nz[i] = (pend[i] != '0);
        assign dec_vec[i] = (state == S_FIRE) && (winner == ID_W'(i));
        assign ovf_hit[i] = req[i] && !dec_vec[i] && (pend[i] == PEND_MAX);
    end

    // Pick the pending requester closest after the round-robin pointer (wrapping).
    always_comb begin
        any_pend = |pend_nz;
        sel_idx  = '0;
        arb_best = NREQ;
        arb_dist = 0;
        for (int j = 0; j < NREQ; j++) begin
            arb_dist = (j + NREQ - int'(rr_ptr)) % NREQ;
            if (pend_nz[j] && (arb_dist < arb_best)) begin
                arb_best = arb_dist;
                sel_idx  = ID_W'(j);
            end
        end
    end

    // A request landing on the decrement cycle cancels it; a full counter drops the request.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                pend[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !dec_vec[i] && !ovf_hit[i]) begin
                    pend[i] <= pend[i] + PEND_ONE;
                end else if (!req[i] && dec_vec[i]) begin
                    pend[i] <= pend[i] - PEND_ONE;
                end
            end
            ovf <= ovf_hit | (ovf & ~{NREQ{clr_ovf}});
        end
    end

    // Arbitration happens on entry to FIRE; FIRE itself issues the pulse and opens the gap.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            winner  <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
            sig_a   <= 1'b0;
            sig_id  <= '0;
        end else begin
            sig_a <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        winner <= sel_idx;
                        state  <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    sig_a   <= 1'b1;
                    sig_id  <= winner;
                    gap_cnt <= GAP_W'(GAP - 1);
                    rr_ptr  <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if (any_pend) begin
                            winner <= sel_idx;
                            state  <= S_FIRE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_FIRE) || (state == S_GAP);

endmodule

// File: tb/tb_pulse_sync_sched.sv
// tb_pulse_sync_sched: vector table, multi-cycle corner sequences and random traffic,
// all checked against a cycle-level scheduling model built from the pulse rules.
module tb_pulse_sync_sched;

    localparam int NREQ  = 4;
    localparam int GAP   = 8;
    localparam int CNT_W = 4;
    localparam int ID_W  = $clog2(NREQ);
`ifdef PULSE_SCHED_CNT_EN
    localparam int PEND_MAX = (1 << CNT_W) - 1;
`else
    localparam int PEND_MAX = 1;
`endif

    logic            clka = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            clr_ovf;
    logic            sig_a;
    logic [ID_W-1:0] sig_id;
    logic            busy;
    logic [NREQ-1:0] ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_pulses;

    always #5 clka = ~clka;

    pulse_sync_sched #(.NREQ(NREQ), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clka    (clka),
        .rst     (rst),
        .req     (req),
        .clr_ovf (clr_ovf),
        .sig_a   (sig_a),
        .sig_id  (sig_id),
        .busy    (busy),
        .ovf     (ovf)
    );

    // Model: counts per requester; a selection edge picks a winner, the next edge fires it,
    // and no selection is allowed until GAP edges after a fire.
    int              m_cnt [NREQ];
    int              m_fire;
    int              m_win;
    int              m_rr;
    int              m_edge;
    int              m_earliest;
    int              m_last_fire;
    int              m_sig_a;
    int              m_sig_id;
    int              m_busy;
    int              m_pulses;
    logic [NREQ-1:0] m_ovf;

    typedef struct {
        logic [NREQ-1:0] req;
        logic            clr;
        logic            sig_a;
        int              id;
        logic            busy;
        logic [NREQ-1:0] ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [NREQ-1:0] r, logic c, logic a, int id, logic b,
                                logic [NREQ-1:0] o);
        vec_t v;
        v.req = r; v.clr = c; v.sig_a = a; v.id = id; v.busy = b; v.ovf = o;
        return v;
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < NREQ; i++) begin
            if (m_cnt[i] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_fire = 0; m_win = 0; m_rr = 0; m_edge = 0; m_earliest = 0;
        m_last_fire = -1000; m_sig_a = 0; m_sig_id = 0; m_busy = 0;
        m_pulses = 0; m_ovf = '0; dut_pulses = 0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic c);
        int dec [NREQ];
        int base;
        int idx;
        logic [NREQ-1:0] hit;
        bit found;
        for (int i = 0; i < NREQ; i++) dec[i] = 0;
        m_sig_a = 0;
        if (m_fire != 0) begin
            dec[m_win]  = 1;
            m_sig_a     = 1;
            m_sig_id    = m_win;
            m_rr        = (m_win + 1) % NREQ;
            m_last_fire = m_edge;
            m_earliest  = m_edge + GAP;
            m_fire      = 0;
            m_pulses++;
        end else if (m_edge >= m_earliest) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (!found && m_cnt[idx] > 0) begin
                    found  = 1'b1;
                    m_win  = idx;
                    m_fire = 1;
                end
            end
        end
        hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            base = m_cnt[i] - dec[i];
            if (r[i]) begin
                if (base == PEND_MAX) hit[i] = 1'b1;
                else base = base + 1;
            end
            m_cnt[i] = base;
        end
        m_ovf  = hit | (c ? '0 : m_ovf);
        m_busy = (m_fire != 0) || ((m_edge - m_last_fire) >= 0 && (m_edge - m_last_fire) < GAP);
        m_edge++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s at %0t: bound expired", name, $time);
    endtask

    task automatic check_output();
        check("sig_a", 32'(sig_a), 32'(m_sig_a));
        check("sig_id", 32'(sig_id), 32'(m_sig_id));
        check("busy", 32'(busy), 32'(m_busy));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (sig_a === 1'b1) dut_pulses++;
    endtask

    task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic c);
        req     = r;
        clr_ovf = c;
        model_edge(r, c);
        @(posedge clka);
        #1;
        check_output();
    endtask

    // Asserted mid-cycle so the asynchronous clear is seen without any clock edge.
    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        clr_ovf = 1'b0;
        #2;
        model_reset();
        check_output();
        #2;
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (((m_fire != 0) || (m_busy != 0) || m_any()) && n < budget) begin
            apply_stimulus('0, 1'b0);
            n++;
        end
        if (n >= budget) fail_now("drain_timeout");
        apply_stimulus('0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int times[$];
        int ids[$];
        int n;

        rst = 1'b1; req = '0; clr_ovf = 1'b0;
        vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 0, 1'b0, 4'b0000));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 0, 1'b1, 4'b0000));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 0, 1'b1, 4'b0000));
        for (int i = 3; i <= 9; i++) vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 0, 1'b1, 4'b0000));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000));

        @(posedge clka);
        #1;
        do_reset();

        // Single request from idle: fixed latency, single pulse, busy for 1+GAP cycles.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].req, vecs[i].clr);
            check($sformatf("vec%0d_sig_a", i), 32'(sig_a), 32'(vecs[i].sig_a));
            check($sformatf("vec%0d_sig_id", i), 32'(sig_id), 32'(vecs[i].id));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end

        // All four requesters at once: ids in order, exactly GAP+1 apart.
        do_reset();
        for (int c = 0; c < 45; c++) begin
            apply_stimulus((c == 0) ? 4'b1111 : 4'b0000, 1'b0);
            if (sig_a === 1'b1) begin
                times.push_back(c);
                ids.push_back(int'(sig_id));
            end
        end
        check("simul_count", 32'(times.size()), 32'(NREQ));
        for (int i = 0; i < ids.size() && i < NREQ; i++) begin
            check($sformatf("simul_id%0d", i), 32'(ids[i]), 32'(i));
            if (i > 0) check($sformatf("simul_space%0d", i), 32'(times[i] - times[i-1]), 32'(GAP + 1));
        end

        // Back-to-back requests from one requester.
        do_reset();
        for (int c = 0; c < 5; c++) apply_stimulus(4'b0100, 1'b0);
        drain(400);
        check("backlog_pulses", 32'(dut_pulses), 32'(m_pulses));

        // Overflow, then overflow colliding with clear, then plain clear.
        do_reset();
        for (int c = 0; c < 19; c++) apply_stimulus(4'b0010, 1'b0);
        apply_stimulus(4'b0010, 1'b1);
        check("ovf_beats_clr", 32'(ovf[1]), 32'(m_ovf[1]));
        apply_stimulus(4'b0000, 1'b1);
        check("ovf_cleared", 32'(ovf[1]), 32'(m_ovf[1]));
        drain(400);
        check("ovf_pulses", 32'(dut_pulses), 32'(m_pulses));

        // Reset while in FIRE, then while sig_a is high: everything queued is discarded.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            n = 0;
            while (n < 12 && !((pass == 0) ? (m_fire != 0) : (m_sig_a != 0))) begin
                apply_stimulus((n < 3) ? 4'b1000 : 4'b0000, 1'b0);
                n++;
            end
            if (n >= 12) fail_now("reach_target_state");
            do_reset();
            check($sformatf("rst%0d_sig_a", pass), 32'(sig_a), 32'(0));
            for (int c = 0; c < 25; c++) apply_stimulus('0, 1'b0);
            check($sformatf("rst%0d_no_pulses", pass), 32'(dut_pulses), 32'(m_pulses));
        end

        // Random traffic: heavy backlog, then sparse 10-50 cycle spaced requests.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [NREQ-1:0] r;
            for (int b = 0; b < NREQ; b++) r[b] = ($urandom_range(0, 11) == 0);
            apply_stimulus(r, $urandom_range(0, 24) == 0);
        end
        for (int k = 0; k < 40; k++) begin
            logic [NREQ-1:0] r;
            r = '0;
            r[$urandom_range(0, NREQ - 1)] = 1'b1;
            apply_stimulus(r, 1'b0);
            n = $urandom_range(9, 49);
            for (int c = 0; c < n; c++) apply_stimulus('0, $urandom_range(0, 30) == 0);
        end
        drain(2000);
        check("random_pulses", 32'(dut_pulses), 32'(m_pulses));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
